// File: rtl/axi_burst_master_if.sv
// AXI4 memory-side bundle for one burst master port.
// The master modport is the burst engine; the slave modport is the memory side.
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;

  logic              arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Turns one native-bus burst request into a single AXI4 INCR burst,
// one write or read in flight at a time.
module axi_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                databus_valid,
  input  logic [ADDR_W-1:0]   databus_addr,
  input  logic [DATA_W-1:0]   databus_wdata,
  input  logic [DATA_W/8-1:0] databus_wstrb,
  input  logic [LEN_W-1:0]    dma_len,
  output logic                databus_ready,
  output logic [DATA_W-1:0]   databus_rdata,
  output logic                error,
  axi_burst_master_if.master  m_axi
);

  localparam int              OFF_W    = $clog2(DATA_W / 8);
  localparam logic [2:0]      AX_SIZE  = 3'(OFF_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    R_ADDR = 3'd4,
    R_DATA = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  count_r;
  logic              awvalid_r;
  logic              wvalid_r;
  logic              bready_r;
  logic              arvalid_r;
  logic              rready_r;
  logic              last_beat_s;

  assign last_beat_s = (count_r == len_r);

  assign m_axi.awid    = 1'b0;
  assign m_axi.awaddr  = addr_r;
  assign m_axi.awlen   = 8'(len_r);
  assign m_axi.awsize  = AX_SIZE;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = awvalid_r;

  // Write data comes straight from the requester; wvalid is masked on ready-pulse cycles.
  assign m_axi.wdata  = databus_wdata;
  assign m_axi.wstrb  = databus_wstrb;
  assign m_axi.wlast  = wvalid_r & last_beat_s;
  assign m_axi.wvalid = wvalid_r;
  assign m_axi.bready = bready_r;

  assign m_axi.arid    = 1'b0;
  assign m_axi.araddr  = addr_r;
  assign m_axi.arlen   = 8'(len_r);
  assign m_axi.arsize  = AX_SIZE;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'b0000;
  assign m_axi.arvalid = arvalid_r;
  assign m_axi.rready  = rready_r;

  // Burst sequencer: latches the request, drives the AXI handshakes, pulses databus_ready per beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      len_r         <= {LEN_W{1'b0}};
      count_r       <= {LEN_W{1'b0}};
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      databus_ready <= 1'b0;
      databus_rdata <= {DATA_W{1'b0}};
      error         <= 1'b0;
    end else begin
      databus_ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (databus_valid) begin
            addr_r  <= databus_addr & ~OFF_MASK;
            len_r   <= dma_len;
            count_r <= {LEN_W{1'b0}};
            error   <= 1'b0;
            if (|databus_wstrb) begin
              awvalid_r <= 1'b1;
              state_r   <= W_ADDR;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= R_ADDR;
            end
          end
        end
        W_ADDR: begin
          if (m_axi.awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            state_r   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid_r && m_axi.wready) begin
            wvalid_r <= 1'b0;
            if (last_beat_s) begin
              bready_r <= 1'b1;
              state_r  <= W_RESP;
            end else begin
              databus_ready <= 1'b1;
              count_r       <= count_r + LEN_W'(1);
            end
          end else if (!wvalid_r) begin
            // Requester has had the ready-pulse cycle to present the next beat.
            wvalid_r <= 1'b1;
          end
        end
        W_RESP: begin
          if (m_axi.bvalid) begin
            bready_r      <= 1'b0;
            databus_ready <= 1'b1;
            error         <= error | (m_axi.bresp != 2'b00);
            state_r       <= DONE;
          end
        end
        R_ADDR: begin
          if (m_axi.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi.rvalid) begin
            databus_rdata <= m_axi.rdata;
            databus_ready <= 1'b1;
            if (m_axi.rlast || last_beat_s) begin
              // A short burst (rlast before the requested length) is flagged as an error.
              rready_r <= 1'b0;
              error    <= error | (m_axi.rresp != 2'b00) | !last_beat_s;
              state_r  <= DONE;
            end else begin
              error   <= error | (m_axi.rresp != 2'b00);
              count_r <= count_r + LEN_W'(1);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
